// File: rtl/seq_alu_mul_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_mul_if
// Brief    : Operand/result handshake bundle for the sequential ALU/multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_mul_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       alu_ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             err;

    modport slave (
        input  in_valid, in1, in2, alu_ctl, out_ready,
        output in_ready, out_valid, result, result_hi, carry_out, overflow, zero, err
    );

    modport master (
        output in_valid, in1, in2, alu_ctl, out_ready,
        input  in_ready, out_valid, result, result_hi, carry_out, overflow, zero, err
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_mul
// Brief    : Handshaked registered ALU with SLT/NOR and shift-add unsigned MUL.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  wire logic      clk,
    input  wire logic      rst,
    seq_alu_mul_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_hi_q;
    logic               carry_q, ovf_q, zero_q, err_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;

    logic               w_accept, w_is_mul;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic               w_as_ovf;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry, w_ovf, w_err;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_accept = bus.in_valid && (state_q == c_IDLE);
    assign w_is_mul = (bus.alu_ctl == 4'b0011);

    // Shared adder: bnegate selects A + ~B + 1, which serves SUB and SLT.
    assign w_b_eff  = bus.alu_ctl[2] ? ~bus.in2 : bus.in2;
    assign w_sum    = {1'b0, bus.in1} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, bus.alu_ctl[2]};
    assign w_as_ovf = (bus.in1[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (bus.alu_ctl)
            4'b0000: w_res = bus.in1 & bus.in2;
            4'b0001: w_res = bus.in1 | bus.in2;
            4'b1100: w_res = ~(bus.in1 | bus.in2);
            4'b0010, 4'b0110: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_as_ovf;
            end
            4'b0111: w_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_as_ovf};
            4'b0011: w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_accept) state_d = w_is_mul ? c_MUL : c_DONE;
            c_MUL:   if (count_q == c_LAST) state_d = c_DONE;
            c_DONE:  if (bus.out_ready) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                if (w_is_mul) begin
                    mcand_q  <= {{WIDTH{1'b0}}, bus.in1};
                    mplier_q <= bus.in2;
                    acc_q    <= '0;
                    count_q  <= '0;
                end else begin
                    result_q    <= w_res;
                    result_hi_q <= '0;
                    carry_q     <= w_carry;
                    ovf_q       <= w_ovf;
                    zero_q      <= (w_res == '0);
                    err_q       <= w_err;
                end
            end
            if (state_q == c_MUL) begin
                acc_q    <= w_acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + CW'(1);
                if (count_q == c_LAST) begin
                    result_q    <= w_acc_next[WIDTH-1:0];
                    result_hi_q <= w_acc_next[2*WIDTH-1:WIDTH];
                    carry_q     <= 1'b0;
                    ovf_q       <= |w_acc_next[2*WIDTH-1:WIDTH];
                    zero_q      <= (w_acc_next[WIDTH-1:0] == '0);
                    err_q       <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == c_IDLE);
    assign bus.out_valid = (state_q == c_DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu_mul
// Brief    : Directed + random scoreboard bench for seq_alu_mul (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu_mul;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         c;
        logic         o;
        logic         z;
        logic         e;
        logic         mul;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    seq_alu_mul_if #(.WIDTH(W)) bus ();

    seq_alu_mul #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl);
        exp_t        r;
        logic [W:0]  s;
        logic [63:0] p;
        r = '0;
        case (ctl)
            4'b0000: r.res = a & b;
            4'b0001: r.res = a | b;
            4'b1100: r.res = ~a & ~b;
            4'b0010: begin
                s     = {1'b0, a} + {1'b0, b};
                r.res = s[W-1:0];
                r.c   = s[W];
                r.o   = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            4'b0110: begin
                s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r.res = s[W-1:0];
                r.c   = s[W];
                r.o   = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: begin
                p     = {32'd0, a} * {32'd0, b};
                r.res = p[31:0];
                r.hi  = p[63:32];
                r.o   = |p[63:32];
                r.mul = 1'b1;
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == '0);
        return r;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.in1      = a;
        bus.in2      = b;
        bus.alu_ctl  = ctl;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in1      = $urandom;
        bus.in2      = $urandom;
        bus.alu_ctl  = 4'($urandom);
        sb.push_back(model(a, b, ctl));
    endtask

    // Waits for a result, optionally stalls it for 'hold' cycles, then consumes it.
    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   lat = 0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), e.mul ? 64'd32 : 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in1      = $urandom;
            bus.in2      = $urandom;
            bus.alu_ctl  = 4'b0010;
            tick();
            check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
            check({tag, "_hold_res"}, 64'(bus.result), 64'(e.res));
        end
        bus.in_valid = 1'b0;
        check({tag, "_res"},  64'(bus.result),    64'(e.res));
        check({tag, "_hi"},   64'(bus.result_hi), 64'(e.hi));
        check({tag, "_flags"}, 64'({bus.carry_out, bus.overflow, bus.zero, bus.err}),
              64'({e.c, e.o, e.z, e.e}));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_ready_after"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
        check({tag, "_res_kept"}, 64'(bus.result), 64'(e.res));
    endtask

    initial begin
        logic [3:0] codes [7];
        logic [3:0] ctl;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.alu_ctl   = '0;
        tick();
        tick();
        check("reset_outputs",
              64'({bus.in_ready, bus.out_valid, bus.carry_out, bus.overflow, bus.zero, bus.err}),
              64'b100000);
        check("reset_res", {bus.result_hi, bus.result}, 64'd0);
        rst = 1'b0;
        tick();

        issue(32'h7FFFFFFF, 32'h00000001, 4'b0010); collect("add_ovf", 0);
        issue(32'h00000001, 32'h00000001, 4'b0110); collect("sub_zero", 0);
        issue(32'h80000000, 32'h00000001, 4'b0111); collect("slt_neg", 0);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0011); collect("mulu_max", 0);
        issue(32'h0000F0F0, 32'h00FF00FF, 4'b1100); collect("nor", 0);

        issue(32'h12345678, 32'h0F0F0F0F, 4'b0000); collect("and_bp", 5);
        issue(32'h00000003, 32'h00000004, 4'b0010); collect("after_bp", 0);

        issue(32'h0001_0001, 32'h0000_FFFF, 4'b0011);
        repeat (9) tick();
        rst = 1'b1;
        #1;
        check("rst_mid_mul", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        check("rst_release", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        issue(32'h00000001, 32'h00000001, 4'b0010); collect("add_after_rst", 0);

        issue(32'hFFFFFFFF, 32'h00000000, 4'b0101); collect("illegal", 0);
        issue(32'h0000000F, 32'h000000A0, 4'b0001); collect("or_legal", 0);

        for (int i = 0; i < 10; i++) begin
            ctl = codes[$urandom_range(0, 6)];
            issue($urandom, $urandom, ctl);
            collect("random", $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
